// File: rtl/acc_control_unit.sv
// acc_control_unit
//   Multi-cycle sequencer and register file for the 8-bit accumulator CPU.
//   Fetches instructions over a req/ack memory handshake, holds PC/IR/DR/AC/E,
//   feeds the downstream ALU and commits its result/carry into AC/E in EXEC.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   mem_req/we/addr/wdata : memory request (write data is AC)
//   mem_rdata, mem_ack    : memory read data and completion strobe
//   alu_ac/alu_dr/alu_sel : ALU operands and selector (IR[7:5])
//   alu_result, alu_carry : ALU result and 9th-bit carry/borrow
//   ac_out, e_out, pc_out : architectural registers
//   halted                : high while in HALT
module acc_control_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] alu_ac,
    output logic [DATA_W-1:0] alu_dr,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic [DATA_W-1:0] ac_out,
    output logic              e_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_START, S_FETCH, S_DECODE, S_OPREAD, S_EXEC, S_STORE, S_HALT
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_CMA = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] dr;
    logic [DATA_W-1:0] ac;
    logic              e;

    logic [2:0]        op;
    logic [ADDR_W-1:0] opnd_addr;

    assign op        = ir[DATA_W-1 -: 3];
    assign opnd_addr = ir[ADDR_W-1:0];

    // Acks are only looked at in the three request states, so a stray ack
    // while mem_req is low can never advance the machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_START;
            pc    <= '0;
            ir    <= '0;
            dr    <= '0;
            ac    <= '0;
            e     <= 1'b0;
        end else begin
            case (state)
                S_START: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 1'b1;   // wraps modulo 2^ADDR_W
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_XOR, OP_LDA: state <= S_OPREAD;
                        OP_SHL, OP_CMA:                 state <= S_EXEC;
                        OP_STA:                         state <= S_STORE;
                        OP_HLT:                         state <= S_HALT;
                        default:                        state <= S_HALT;
                    endcase
                end
                S_OPREAD: begin
                    if (mem_ack) begin
                        dr    <= mem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_LDA: ac <= dr;
                        OP_ADD, OP_SUB, OP_SHL: begin
                            ac <= alu_result;
                            e  <= alu_carry;
                        end
                        // XOR/CMA: result only, E untouched
                        default: ac <= alu_result;
                    endcase
                    state <= S_FETCH;
                end
                S_STORE: begin
                    if (mem_ack) state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_START;
            endcase
        end
    end

    // Memory request is a pure decode of registered state, so it holds
    // steady across any number of wait cycles.
    always_comb begin
        mem_req   = (state == S_FETCH) || (state == S_OPREAD) || (state == S_STORE);
        mem_we    = (state == S_STORE);
        mem_addr  = (state == S_FETCH) ? pc : opnd_addr;
        mem_wdata = ac;
    end

    assign alu_ac  = ac;
    assign alu_dr  = dr;
    assign alu_sel = op;
    assign ac_out  = ac;
    assign e_out   = e;
    assign pc_out  = pc;
    assign halted  = (state == S_HALT);

endmodule

// File: doc/acc_control_unit.md
# acc_control_unit

Multi-cycle sequencer and register file for the 8-bit accumulator CPU. It sits directly upstream of the ALU stage. It fetches instructions from a 32-word unified memory over a req/ack handshake and holds PC, IR, DR, AC and E. It drives the ALU's AC, DR and selector inputs, then commits the ALU result and carry back into AC/E.

## Interface
Parameters:
- ADDR_W, 5, memory address width (32 words); PC wraps modulo 2^ADDR_W
- DATA_W, 8, data/instruction width; fixed at 8 (opcode in [7:5], address in [4:0])

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  5  transaction address
- mem_wdata  out  8  write data (AC); valid while mem_req && mem_we
- mem_rdata  in  8  read data; valid in the cycle mem_req && mem_ack && !mem_we
- mem_ack  in  1  transaction completes in the cycle mem_req && mem_ack
- alu_ac  out  8  AC register value to ALU
- alu_dr  out  8  DR register value to ALU
- alu_sel  out  3  ALU selector, equals IR[7:5]
- alu_result  in  8  ALU result (combinational from alu_ac/alu_dr/alu_sel)
- alu_carry  in  1  carry/borrow out of the 9-bit ALU add/sub/shift
- ac_out  out  8  AC register
- e_out  out  1  E flag register
- pc_out  out  5  PC register
- halted  out  1  high while in HALT

## Operation
- Opcodes (IR[7:5]):
  - 000 ADD, 001 SUB, 010 XOR, 011 SHL (AC+AC), 110 CMA (~AC): ALU ops.
  - 100 LDA (AC<=M[a]), 101 STA (M[a]<=AC), 111 HLT.
  - a = IR[4:0]. SHL, CMA and HLT ignore a.
- States: START, FETCH, DECODE, OPREAD, EXEC, STORE, HALT.
- START: mem_req=0 → FETCH.
- FETCH: mem_req=1, we=0, addr=PC. On ack: IR<=mem_rdata, PC<=PC+1 (31→0), → DECODE. Without ack, hold.
- DECODE: no memory activity.
  - ADD/SUB/XOR/LDA → OPREAD.
  - SHL/CMA → EXEC.
  - STA → STORE.
  - HLT → HALT.
- OPREAD: mem_req=1, we=0, addr=a. On ack: DR<=mem_rdata, → EXEC.
- EXEC:
  - ALU ops: AC<=alu_result. E<=alu_carry for ADD/SUB/SHL; E unchanged for XOR/CMA.
  - LDA: AC<=DR, E unchanged.
  - → FETCH.
- STORE: mem_req=1, we=1, addr=a, wdata=AC. On ack → FETCH. AC/E unchanged.
- HALT: absorbing. mem_req=0, halted=1. Only reset exits.
- Opcode 111 is the only halt. No opcode is unused: all 8 codes are decoded.
- Arithmetic is modulo 256. E is the only overflow record.

## Timing
- Reset values: PC=0, IR=0, DR=0, AC=0, E=0, state=START. Outputs: mem_req=0, mem_we=0, halted=0, alu_sel=000.
- mem_req/mem_we/mem_addr/mem_wdata are decoded from the registered state and IR/PC/AC. They are stable for every cycle a request is pending.
- Handshake:
  - Ack may arrive in the same cycle req first rises (zero wait).
  - Wait states are unbounded.
  - mem_ack while mem_req=0 is ignored.
  - At most one transaction completes per cycle.
  - mem_req drops (or readdresses) the cycle after completion.
- Latency, zero-wait memory: ADD/SUB/XOR/LDA 4 cycles; SHL/CMA/STA 3; HLT 2 then HALT. Each wait cycle adds 1.
- alu_ac/alu_dr/alu_sel are sampled into AC only in EXEC. AC/E change exactly on the EXEC→FETCH edge.
- Reset asserted in any state, including mid-transaction with mem_req high:
  - next cycle is START with mem_req=0;
  - the pending transaction is abandoned;
  - no register keeps its pre-reset value.
- Reset has priority over ack in the same cycle.

## Test plan
- Program M0=0x8A (LDA 10), M1=0x0B (ADD 11), M2=0xAC (STA 12), M3=0xE0 (HLT); M10=0x05, M11=0x07, zero-wait. Required:
  - write M12=0x0C; ac_out=0x0C, e_out=0;
  - halted first high in cycle 15 after reset release (START = cycle 1);
  - pc_out=4 in HALT.
- AC=0x03, SUB with M[a]=0x05 and behavioural ALU model supplying borrow → AC=0xFE, e_out=1. Follow with XOR: E stays 1.
- AC=0x81 via LDA, then SHL → AC=0x02, E=1. Then CMA → AC=0xFD, E=1, no memory read issued for either.
- Insert 3 wait states on every ack → mem_req/addr/we stay stable through the waits. Each instruction lengthens by 3 per access; results identical to the zero-wait run.
- Assert reset for one cycle during an OPREAD with mem_req high → next cycle mem_req=0, state START. PC/AC/E=0, refetch from address 0.
- PC at 31 executing a non-halting instruction → pc_out wraps to 0 and the next fetch uses address 0.
